// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed hex driver for common-anode 7-segment digits, tear-free frame commit.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] val,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              leds,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic                    r_run, w_tc, w_wrap, w_off;
  logic [4*NUM_DIGITS-1:0] r_pv, r_sv, w_sv;
  logic [NUM_DIGITS-1:0]   r_pd, r_pb, r_sd, r_sb, w_sd, w_sb, w_sup;
  logic [3:0]              w_nib;
`ifdef SEG7_LZ_BLANK_EN
  logic                    w_lz;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'ha: glyph = 7'h08;
      4'hb: glyph = 7'h03;
      4'hc: glyph = 7'h46;
      4'hd: glyph = 7'h21;
      4'he: glyph = 7'h06;
      default: glyph = 7'h0e;
    endcase
  endfunction

  // r_run holds the prescaler for the first post-reset cycle so digit 0 gets a full slot on screen
  always_comb begin
    w_tc      = r_run && r_pre == PW'(CLK_DIV - 1);
    w_wrap    = w_tc && r_idx == IW'(NUM_DIGITS - 1);
    w_idx_nxt = w_wrap ? '0 : w_tc ? r_idx + 1'b1 : r_idx;
    w_sv      = w_wrap ? (load ? val : r_pv) : r_sv;
    w_sd      = w_wrap ? (load ? dp_in : r_pd) : r_sd;
    w_sb      = w_wrap ? (load ? blank : r_pb) : r_sb;
    w_sup     = '0;
`ifdef SEG7_LZ_BLANK_EN
    w_lz      = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lz     = w_lz && w_sv[4*i +: 4] == 4'h0;
      w_sup[i] = w_lz && !w_sd[i];
    end
`endif
    w_nib     = w_sv[4*w_idx_nxt +: 4];
    w_off     = w_sb[w_idx_nxt] || w_sup[w_idx_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_pre      <= '0;
      r_idx      <= '0;
      r_pv       <= '0;
      r_pd       <= '0;
      r_pb       <= '0;
      r_sv       <= '0;
      r_sd       <= '0;
      r_sb       <= '0;
      leds       <= 7'h7f;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_pre      <= w_tc ? '0 : r_run ? r_pre + 1'b1 : r_pre;
      r_idx      <= w_idx_nxt;
      r_pv       <= load ? val : r_pv;
      r_pd       <= load ? dp_in : r_pd;
      r_pb       <= load ? blank : r_pb;
      r_sv       <= w_sv;
      r_sd       <= w_sd;
      r_sb       <= w_sb;
      leds       <= w_off ? 7'h7f : glyph(w_nib);
      dp         <= w_off || !w_sd[w_idx_nxt];
      an         <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      frame_done <= w_wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed scoreboard bench for seg7_scan_mux with NUM_DIGITS=4, CLK_DIV=4.
module tb_seg7_scan_mux;
  typedef struct {
    logic [3:0] an;
    logic [6:0] leds;
    logic       dp;
    logic       fd;
    int         k;
  } exp_t;

  logic        clk = 0, reset = 1, load = 0;
  logic [15:0] val = '0;
  logic [3:0]  dp_in = '0, blank = '0;
  logic [6:0]  leds;
  logic        dp, frame_done;
  logic [3:0]  an;

  exp_t        q[$];
  int          tests = 0, failed = 0, k = 0;
  logic [6:0]  cur_l[4], pend_l[4];
  logic [3:0]  cur_d, pend_d;

  seg7_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .val(val), .dp_in(dp_in), .blank(blank), .load(load),
    .leds(leds), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (an !== e.an || leds !== e.leds || dp !== e.dp || frame_done !== e.fd) begin
        failed++;
        $display("FAIL scan k=%0d: got an=%b leds=%b dp=%b fd=%b, want an=%b leds=%b dp=%b fd=%b",
                 e.k, an, leds, dp, frame_done, e.an, e.leds, e.dp, e.fd);
      end
    end
  end

  task automatic zero_frame();
`ifdef SEG7_LZ_BLANK_EN
    pend_l = '{7'h40, 7'h7f, 7'h7f, 7'h7f};
`else
    pend_l = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    pend_d = 4'b1111;
    cur_l  = pend_l;
    cur_d  = pend_d;
  endtask

  task automatic rtick();
    reset = 1;
    q.push_back('{an: 4'hf, leds: 7'h7f, dp: 1'b1, fd: 1'b0, k: -1});
    @(posedge clk); #1;
    reset = 0;
    load  = 0;
    k     = 0;
    zero_frame();
  endtask

  task automatic tick();
    int s, d;
    logic w;
    logic [3:0] a;
    k++;
    s = (k - 1) % 16;
    d = s / 4;
    w = k > 1 && s == 0;
    if (w) begin
      cur_l = pend_l;
      cur_d = pend_d;
    end
    a = ~(4'b0001 << d);
    q.push_back('{an: a, leds: cur_l[d], dp: cur_d[d], fd: w, k: k});
    @(posedge clk); #1;
    load = 0;
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  task automatic set_pend(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] bl,
                          input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                          input logic [6:0] g0, input logic [3:0] edp);
    val    = v;
    dp_in  = dpi;
    blank  = bl;
    load   = 1;
    pend_l = '{g0, g1, g2, g3};
    pend_d = edp;
  endtask

  initial begin
    zero_frame();
    rtick();
    rtick();
    run_to(40);
    set_pend(16'hA3F0, 4'b0100, 4'b0000, 7'h08, 7'h30, 7'h0e, 7'h40, 4'b1011);
    run_to(60);
    set_pend(16'h1111, 4'b0000, 4'b0000, 7'h79, 7'h79, 7'h79, 7'h79, 4'b1111);
    run_to(62);
    set_pend(16'h2222, 4'b0000, 4'b0000, 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);
    run_to(96);
    set_pend(16'h9999, 4'b0000, 4'b0000, 7'h10, 7'h10, 7'h10, 7'h10, 4'b1111);
    run_to(120);
    set_pend(16'h8888, 4'b0000, 4'b1010, 7'h7f, 7'h00, 7'h7f, 7'h00, 4'b1111);
    run_to(150);
`ifdef SEG7_LZ_BLANK_EN
    set_pend(16'h0042, 4'b0000, 4'b0000, 7'h7f, 7'h7f, 7'h19, 7'h24, 4'b1111);
`else
    set_pend(16'h0042, 4'b0000, 4'b0000, 7'h40, 7'h40, 7'h19, 7'h24, 4'b1111);
`endif
    run_to(182);
    set_pend(16'h5555, 4'b1111, 4'b0000, 7'h12, 7'h12, 7'h12, 7'h12, 4'b0000);
    run_to(186);
    rtick();
    run_to(40);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
